// File: rtl/approx_pkg.sv
// rtl/approx_pkg.sv - shared state encoding and reference approximate-sum function
package approx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_W = 64;

    // Low k bits are carry-less XOR; bits k..n-1 form an exact ripple add
    // starting with carry 0; bit n holds the final carry.
    function automatic logic [MAX_W:0] approx_xor_sum(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               n,
        input int               k
    );
        logic [MAX_W:0] s;
        logic           c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) begin
                if (i < k) begin
                    s[i] = a[i] ^ b[i];
                end else begin
                    s[i] = a[i] ^ b[i] ^ c;
                    c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
                end
            end
        end
        s = s | ((MAX_W+1)'(c) << n);
        return s;
    endfunction

endpackage

// File: rtl/approx_add_err_monitor_if.sv
// rtl/approx_add_err_monitor_if.sv - operand stream and per-sample result bundle
interface approx_add_err_monitor_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic [N:0]   exact_sum;
    logic [N:0]   approx_sum;
    logic [N:0]   ed;

    modport master (
        output in_valid, a, b,
        input  in_ready, out_valid, exact_sum, approx_sum, ed
    );

    modport slave (
        input  in_valid, a, b,
        output in_ready, out_valid, exact_sum, approx_sum, ed
    );
endinterface

// File: rtl/approx_xor_adder.sv
// rtl/approx_xor_adder.sv - combinational K-bit-XOR approximate adder
module approx_xor_adder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);
    generate
        if (K == 0) begin : g_exact
            assign sum = {1'b0, a} + {1'b0, b};
        end else begin : g_approx
            logic [K-1:0] lo;
            for (genvar i = 0; i < K; i++) begin : g_cxor
                cxor u_cxor (.x(a[i]), .y(b[i]), .z(lo[i]));
            end
            if (K == N) begin : g_all_xor
                assign sum = {1'b0, lo};
            end else begin : g_hi
                // Upper part adds with carry-in 0: the low carry is dropped.
                logic [N-K:0] hi;
                assign hi  = {1'b0, a[N-1:K]} + {1'b0, b[N-1:K]};
                assign sum = {hi, lo};
            end
        end
    endgenerate
endmodule

// File: rtl/cxor.sv
// rtl/cxor.sv - carry-less XOR cell used for the approximated low bits
module cxor (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = x ^ y;
endmodule

// File: rtl/approx_add_err_monitor.sv
// rtl/approx_add_err_monitor.sv - approximate-adder error-distance monitor with run statistics
module approx_add_err_monitor
    import approx_pkg::*;
#(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    approx_add_err_monitor_if.slave bus,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     ed_sum,
    output logic [N:0]           ed_max,
    output logic                 busy,
    output logic                 done
);
    localparam int SUM_W = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   num_q, num_nxt;
    logic [CNT_W-1:0]   acc_q, acc_nxt;
    logic               in_ready_q, in_ready_nxt;
    logic               clr_stats;
    logic               xfer;

    logic               s1_valid;
    logic [N-1:0]       s1_a, s1_b;

    logic [N:0]         approx_c, exact_c, ed_c;
    logic               out_valid_q;
    logic [N:0]         exact_q, approx_q, ed_q;

    logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
    logic [ACC_W-1:0]   ed_sum_q, ed_sum_nxt;
    logic [N:0]         ed_max_q;
    logic [SUM_W-1:0]   sum_wide;

    assign xfer = bus.in_valid && in_ready_q;

    // Next state, run length latch, accepted count and registered in_ready
    always_comb begin
        state_nxt = state;
        num_nxt   = num_q;
        acc_nxt   = acc_q;
        clr_stats = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    num_nxt   = num_samples;
                    acc_nxt   = '0;
                    clr_stats = 1'b1;
                    state_nxt = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_nxt = acc_q + 1'b1;
                end
                if (acc_nxt == num_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (sample_cnt_q == num_q) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt = (state_nxt == RUN) && (acc_nxt < num_nxt);
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            num_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            num_q      <= num_nxt;
            acc_q      <= acc_nxt;
            in_ready_q <= in_ready_nxt;
        end
    end

    // S1: capture the accepted operand pair
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_a <= bus.a;
                s1_b <= bus.b;
            end
        end
    end

    approx_xor_adder #(.N(N), .K(K)) u_adder (
        .a   (s1_a),
        .b   (s1_b),
        .sum (approx_c)
    );

    assign exact_c = {1'b0, s1_a} + {1'b0, s1_b};
    assign ed_c    = exact_c - approx_c;

    // S2: register per-sample results; they hold while no new sample arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            exact_q     <= '0;
            approx_q    <= '0;
            ed_q        <= '0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                exact_q  <= exact_c;
                approx_q <= approx_c;
                ed_q     <= ed_c;
            end
        end
    end

    assign sum_wide   = SUM_W'(ed_sum_q) + SUM_W'(ed_q);
    assign ed_sum_nxt = (sum_wide > ACC_MAX) ? '1 : sum_wide[ACC_W-1:0];

    // Run statistics, folded in the cycle after each out_valid
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            ed_sum_q     <= '0;
            ed_max_q     <= '0;
        end else if (out_valid_q) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
            err_cnt_q    <= err_cnt_q + CNT_W'(ed_q != '0);
            ed_sum_q     <= ed_sum_nxt;
            if (ed_q > ed_max_q) begin
                ed_max_q <= ed_q;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.exact_sum  = exact_q;
    assign bus.approx_sum = approx_q;
    assign bus.ed         = ed_q;

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign ed_sum     = ed_sum_q;
    assign ed_max     = ed_max_q;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);
endmodule

// File: tb/tb_approx_add_err_monitor.sv
// tb/tb_approx_add_err_monitor.sv - scoreboard bench over four parameter variants driven in lockstep
module tb_approx_add_err_monitor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } smp_t;

    localparam int K_OF    [4] = '{4, 0, 8, 4};
    localparam int ACCW_OF [4] = '{32, 32, 32, 5};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [7:0]  a, b;

    logic        rdy  [4];
    logic        ov   [4];
    logic [8:0]  exs  [4];
    logic [8:0]  aps  [4];
    logic [8:0]  eds  [4];
    logic [15:0] scnt [4];
    logic [15:0] ecnt [4];
    logic [31:0] esum [4];
    logic [8:0]  emax [4];
    logic        bsy  [4];
    logic        dn   [4];
    logic [4:0]  sum3;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ov_cnt, ov_first, ov_last;

    smp_t               sbq [$];
    int unsigned        m_cnt [4];
    int unsigned        m_err [4];
    longint unsigned    m_sum [4];
    logic [8:0]         m_max [4];

    always #5 clk = ~clk;

    // Cycle counter for throughput measurement
    always @(posedge clk) cyc <= cyc + 1;

    approx_add_err_monitor_if #(.N(8)) bus0 ();
    approx_add_err_monitor_if #(.N(8)) bus1 ();
    approx_add_err_monitor_if #(.N(8)) bus2 ();
    approx_add_err_monitor_if #(.N(8)) bus3 ();

    assign bus0.in_valid = in_valid; assign bus0.a = a; assign bus0.b = b;
    assign bus1.in_valid = in_valid; assign bus1.a = a; assign bus1.b = b;
    assign bus2.in_valid = in_valid; assign bus2.a = a; assign bus2.b = b;
    assign bus3.in_valid = in_valid; assign bus3.a = a; assign bus3.b = b;

    assign rdy[0] = bus0.in_ready; assign ov[0] = bus0.out_valid;
    assign exs[0] = bus0.exact_sum; assign aps[0] = bus0.approx_sum; assign eds[0] = bus0.ed;
    assign rdy[1] = bus1.in_ready; assign ov[1] = bus1.out_valid;
    assign exs[1] = bus1.exact_sum; assign aps[1] = bus1.approx_sum; assign eds[1] = bus1.ed;
    assign rdy[2] = bus2.in_ready; assign ov[2] = bus2.out_valid;
    assign exs[2] = bus2.exact_sum; assign aps[2] = bus2.approx_sum; assign eds[2] = bus2.ed;
    assign rdy[3] = bus3.in_ready; assign ov[3] = bus3.out_valid;
    assign exs[3] = bus3.exact_sum; assign aps[3] = bus3.approx_sum; assign eds[3] = bus3.ed;
    assign esum[3] = {27'd0, sum3};

    approx_add_err_monitor #(.N(8), .K(4), .CNT_W(16), .ACC_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus0),
        .sample_cnt(scnt[0]), .err_cnt(ecnt[0]), .ed_sum(esum[0]), .ed_max(emax[0]),
        .busy(bsy[0]), .done(dn[0])
    );
    approx_add_err_monitor #(.N(8), .K(0), .CNT_W(16), .ACC_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus1),
        .sample_cnt(scnt[1]), .err_cnt(ecnt[1]), .ed_sum(esum[1]), .ed_max(emax[1]),
        .busy(bsy[1]), .done(dn[1])
    );
    approx_add_err_monitor #(.N(8), .K(8), .CNT_W(16), .ACC_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus2),
        .sample_cnt(scnt[2]), .err_cnt(ecnt[2]), .ed_sum(esum[2]), .ed_max(emax[2]),
        .busy(bsy[2]), .done(dn[2])
    );
    approx_add_err_monitor #(.N(8), .K(4), .CNT_W(16), .ACC_W(5)) dut3 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus3),
        .sample_cnt(scnt[3]), .err_cnt(ecnt[3]), .ed_sum(sum3), .ed_max(emax[3]),
        .busy(bsy[3]), .done(dn[3])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_approx(input logic [7:0] x, input logic [7:0] y, input int k);
        logic [8:0] lowmask, hi;
        lowmask = (9'd1 << k) - 9'd1;
        hi      = ({1'b0, x} >> k) + ({1'b0, y} >> k);
        return (hi << k) | ({1'b0, x ^ y} & lowmask);
    endfunction

    // Scoreboard: pop on each out_valid, compare every variant, fold the stats model
    always @(negedge clk) begin : monitor
        smp_t       p;
        logic [8:0] ex, ap, ev;
        longint unsigned lim;
        if (rst === 1'b0) begin
            for (int c = 1; c < 4; c++) begin
                check($sformatf("ov_lockstep%0d", c), ov[c], ov[0]);
            end
            if (ov[0] === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("spurious_out_valid", ov[0], 0);
                end else begin
                    p = sbq.pop_front();
                    for (int c = 0; c < 4; c++) begin
                        ex = {1'b0, p.a} + {1'b0, p.b};
                        ap = model_approx(p.a, p.b, K_OF[c]);
                        ev = ex - ap;
                        check($sformatf("exact%0d a=%0h b=%0h", c, p.a, p.b), exs[c], ex);
                        check($sformatf("approx%0d a=%0h b=%0h", c, p.a, p.b), aps[c], ap);
                        check($sformatf("ed%0d a=%0h b=%0h", c, p.a, p.b), eds[c], ev);
                        lim = (64'd1 << ACCW_OF[c]) - 64'd1;
                        m_cnt[c]++;
                        if (ev != 9'd0) m_err[c]++;
                        m_sum[c] = m_sum[c] + ev;
                        if (m_sum[c] > lim) m_sum[c] = lim;
                        if (ev > m_max[c]) m_max[c] = ev;
                    end
                    ov_cnt++;
                    if (ov_cnt == 1) ov_first = cyc;
                    ov_last = cyc;
                end
            end
        end
    end

    task automatic clear_model();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0; m_err[c] = 0; m_sum[c] = 0; m_max[c] = '0;
        end
        ov_cnt = 0; ov_first = 0; ov_last = 0;
    endtask

    task automatic pulse_start(input int n);
        clear_model();
        start = 1'b1;
        num_samples = 16'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        int t = 0;
        a = x; b = y; in_valid = 1'b1;
        while (rdy[0] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (rdy[0] === 1'b1) sbq.push_back('{x, y});
        else check("accept_timeout", rdy[0], 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (dn[0] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_reached"}, dn[0], 1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_done%0d", tag, c), dn[c], 1);
            check($sformatf("%s_busy%0d", tag, c), bsy[c], 0);
            check($sformatf("%s_sample_cnt%0d", tag, c), scnt[c], m_cnt[c]);
            check($sformatf("%s_err_cnt%0d", tag, c), ecnt[c], m_err[c]);
            check($sformatf("%s_ed_sum%0d", tag, c), esum[c], m_sum[c]);
            check($sformatf("%s_ed_max%0d", tag, c), emax[c], m_max[c]);
        end
    endtask

    task automatic outputs_zero(input string tag);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_in_ready%0d", tag, c), rdy[c], 0);
            check($sformatf("%s_out_valid%0d", tag, c), ov[c], 0);
            check($sformatf("%s_exact%0d", tag, c), exs[c], 0);
            check($sformatf("%s_approx%0d", tag, c), aps[c], 0);
            check($sformatf("%s_ed%0d", tag, c), eds[c], 0);
            check($sformatf("%s_sample_cnt%0d", tag, c), scnt[c], 0);
            check($sformatf("%s_err_cnt%0d", tag, c), ecnt[c], 0);
            check($sformatf("%s_ed_sum%0d", tag, c), esum[c], 0);
            check($sformatf("%s_ed_max%0d", tag, c), emax[c], 0);
            check($sformatf("%s_busy%0d", tag, c), bsy[c], 0);
            check($sformatf("%s_done%0d", tag, c), dn[c], 0);
        end
    endtask

    initial begin
        int pushed;
        int t;
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0; a = '0; b = '0;
        clear_model();
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed K=4 vectors
        pulse_start(3);
        check("dir_busy", bsy[0], 1);
        check("dir_in_ready", rdy[0], 1);
        send(8'h0F, 8'h01);
        send(8'hFF, 8'hFF);
        send(8'h30, 8'h41);
        wait_done("dir");
        check("dir_const_sample_cnt", scnt[0], 3);
        check("dir_const_err_cnt", ecnt[0], 2);
        check("dir_const_ed_sum", esum[0], 32);
        check("dir_const_ed_max", emax[0], 9'h01E);
        check("dir_hold_exact", exs[0], 9'h071);
        check("dir_hold_ed", eds[0], 0);

        // Saturating accumulator on the ACC_W=5 variant
        pulse_start(4);
        repeat (4) send(8'hFF, 8'hFF);
        wait_done("sat");
        check("sat_const_ed_sum_acc5", esum[3], 31);
        check("sat_const_ed_sum_acc32", esum[0], 120);

        // K=N corner
        pulse_start(1);
        send(8'h80, 8'h80);
        wait_done("kn");
        check("kn_const_approx", aps[2], 9'h000);
        check("kn_const_ed", eds[2], 9'h100);
        check("kn_const_ed_max", emax[2], 9'h100);

        // Back-to-back streaming
        pulse_start(100);
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom), 8'($urandom));
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        check("stream_in_ready_drop", rdy[0], 0);
        wait_done("stream");
        check("stream_ov_count", ov_cnt, 100);
        check("stream_no_bubbles", ov_last - ov_first, 99);
        check("stream_const_sample_cnt", scnt[0], 100);

        // Zero-length run
        pulse_start(0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("zero_done%0d", c), dn[c], 1);
            check($sformatf("zero_sample_cnt%0d", c), scnt[c], 0);
            check($sformatf("zero_ed_sum%0d", c), esum[c], 0);
            check($sformatf("zero_ed_max%0d", c), emax[c], 0);
        end

        // start while busy is ignored
        pulse_start(3);
        send(8'h12, 8'h34);
        start = 1'b1; num_samples = 16'd7;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", bsy[0], 1);
        send(8'hAB, 8'hCD);
        send(8'h0F, 8'h0F);
        wait_done("ign");
        check("ign_const_sample_cnt", scnt[0], 3);

        // Reset mid-run drops in-flight samples
        pulse_start(5);
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        #1;
        sbq.delete();
        rst = 1'b1;
        @(negedge clk);
        outputs_zero("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_idle_busy", bsy[0], 0);
        check("midrst_idle_done", dn[0], 0);
        check("midrst_idle_ready", rdy[0], 0);

        // Random backpressure
        pulse_start(50);
        pushed = 0;
        t = 0;
        while (pushed < 50 && t < 1000) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            if (in_valid && rdy[0] === 1'b1) begin
                sbq.push_back('{a, b});
                pushed++;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        wait_done("bp");
        check("bp_const_sample_cnt", scnt[0], 50);
        check("bp_k0_err_cnt", ecnt[1], 0);
        check("bp_k0_ed_max", emax[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
